// File: rtl/wb_regfile_pkg.sv
// Shared register-file bus widths and constants for the write-back register file.
// The HI/LO extension is controlled by the WB_HILO_EN macro in wb_regfile.sv.
package wb_regfile_pkg;

  localparam int REG_DATA_BUS = 32;
  localparam int REG_ADDR_BUS = 5;
  localparam int REG_NUM      = 32;

  localparam logic [REG_ADDR_BUS-1:0] ZERO_REG_ADDR = 5'd0;
  localparam logic [REG_DATA_BUS-1:0] ZERO_WORD     = 32'd0;

  // Address match used for the write-through bypass.
  function automatic logic addr_match(input logic [REG_ADDR_BUS-1:0] a,
                                      input logic [REG_ADDR_BUS-1:0] b);
    return a == b;
  endfunction

endpackage

// File: rtl/wb_regfile_read_port.sv
// Combinational read mux: reset, enable, zero register, same-cycle write bypass,
// then stored value. ZERO_GATE=0 turns off the register-0 rule (used for HI/LO).
module wb_regfile_read_port
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W    = REG_DATA_BUS,
  parameter int ADDR_W    = REG_ADDR_BUS,
  parameter bit ZERO_GATE = 1'b1
) (
  input  logic              rst,
  input  logic              read_en,
  input  logic [ADDR_W-1:0] read_addr,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] array_data,
  output logic [DATA_W-1:0] read_data
);

  logic is_zero;
  logic hit;

  assign is_zero = ZERO_GATE && (read_addr == '0);
  assign hit     = write_en && (write_addr == read_addr);

  always_comb begin
    read_data = DATA_W'(ZERO_WORD);
    if (rst && read_en && !is_zero) begin
      if (hit) begin
        read_data = write_data;
      end else begin
        read_data = array_data;
      end
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Architectural register file fed by write-back, two bypassed read ports.
// Define WB_HILO_EN to add the HI/LO multiply/divide result registers.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_BUS,
  parameter int ADDR_W   = REG_ADDR_BUS,
  parameter int NUM_REGS = REG_NUM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_reg_write_en,
  input  logic [ADDR_W-1:0] wb_reg_write_addr,
  input  logic [DATA_W-1:0] wb_reg_write_data,
  input  logic              reg1_read_en,
  input  logic [ADDR_W-1:0] reg1_read_addr,
  output logic [DATA_W-1:0] reg1_read_data,
  input  logic              reg2_read_en,
  input  logic [ADDR_W-1:0] reg2_read_addr,
`ifdef WB_HILO_EN
  input  logic              wb_hi_write_en,
  input  logic              wb_lo_write_en,
  input  logic [DATA_W-1:0] wb_hi_write_data,
  input  logic [DATA_W-1:0] wb_lo_write_data,
  output logic [DATA_W-1:0] hi_read_data,
  output logic [DATA_W-1:0] lo_read_data,
`endif
  output logic [DATA_W-1:0] reg2_read_data
);

  if (NUM_REGS != (1 << ADDR_W)) begin : g_bad_num_regs
    $error("wb_regfile: NUM_REGS must equal 2**ADDR_W");
  end

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_ok;

  assign wr_ok = wb_reg_write_en && (wb_reg_write_addr != ADDR_W'(ZERO_REG_ADDR));

  // Async clear also swallows any write strobe present while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[wb_reg_write_addr] <= wb_reg_write_data;
    end
  end

  wb_regfile_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_GATE(1'b1)
  ) u_port1 (
    .rst       (rst),
    .read_en   (reg1_read_en),
    .read_addr (reg1_read_addr),
    .write_en  (wb_reg_write_en),
    .write_addr(wb_reg_write_addr),
    .write_data(wb_reg_write_data),
    .array_data(regs[reg1_read_addr]),
    .read_data (reg1_read_data)
  );

  wb_regfile_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_GATE(1'b1)
  ) u_port2 (
    .rst       (rst),
    .read_en   (reg2_read_en),
    .read_addr (reg2_read_addr),
    .write_en  (wb_reg_write_en),
    .write_addr(wb_reg_write_addr),
    .write_data(wb_reg_write_data),
    .array_data(regs[reg2_read_addr]),
    .read_data (reg2_read_data)
  );

`ifdef WB_HILO_EN
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (wb_hi_write_en) hi_q <= wb_hi_write_data;
      if (wb_lo_write_en) lo_q <= wb_lo_write_data;
    end
  end

  // Single-entry ports: addresses tied equal so the bypass depends only on the enable.
  wb_regfile_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (1),
    .ZERO_GATE(1'b0)
  ) u_hi_port (
    .rst       (rst),
    .read_en   (1'b1),
    .read_addr (1'b0),
    .write_en  (wb_hi_write_en),
    .write_addr(1'b0),
    .write_data(wb_hi_write_data),
    .array_data(hi_q),
    .read_data (hi_read_data)
  );

  wb_regfile_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (1),
    .ZERO_GATE(1'b0)
  ) u_lo_port (
    .rst       (rst),
    .read_en   (1'b1),
    .read_addr (1'b0),
    .write_en  (wb_lo_write_en),
    .write_addr(1'b0),
    .write_data(wb_lo_write_data),
    .array_data(lo_q),
    .read_data (lo_read_data)
  );
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed vector table, hand-written reset
// sequences, and randomized traffic against an array-based reference model.
module tb_wb_regfile;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic          e1, e2;
  logic [AW-1:0] a1, a2;
  logic [DW-1:0] d1, d2;
`ifdef WB_HILO_EN
  logic          hwe, lwe;
  logic [DW-1:0] hwd, lwd, hrd, lrd;
`endif

  always #5 clk = ~clk;

  wb_regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
    .clk              (clk),
    .rst              (rst),
    .wb_reg_write_en  (we),
    .wb_reg_write_addr(wa),
    .wb_reg_write_data(wd),
    .reg1_read_en     (e1),
    .reg1_read_addr   (a1),
    .reg1_read_data   (d1),
    .reg2_read_en     (e2),
    .reg2_read_addr   (a2),
`ifdef WB_HILO_EN
    .wb_hi_write_en   (hwe),
    .wb_lo_write_en   (lwe),
    .wb_hi_write_data (hwd),
    .wb_lo_write_data (lwd),
    .hi_read_data     (hrd),
    .lo_read_data     (lrd),
`endif
    .reg2_read_data   (d2)
  );

  logic [DW-1:0] model [NR];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          e1;
    logic [AW-1:0] a1;
    logic          e2;
    logic [AW-1:0] a2;
    logic [DW-1:0] x1;
    logic [DW-1:0] x2;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference read: what the architecture promises for one read port right now.
  function automatic logic [DW-1:0] ref_read(input logic en, input logic [AW-1:0] addr);
    if (!rst || !en || addr == 0) return '0;
    if (we && wa == addr) return wd;
    return model[addr];
  endfunction

  task automatic drive(input logic w, input logic [AW-1:0] wad, input logic [DW-1:0] wdat,
                       input logic en1, input logic [AW-1:0] ad1,
                       input logic en2, input logic [AW-1:0] ad2);
    we = w; wa = wad; wd = wdat; e1 = en1; a1 = ad1; e2 = en2; a2 = ad2;
  endtask

  // Advance one clock edge, updating the model, and return at the next falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst && we && wa != 0) model[wa] = wd;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) model[i] = '0;
    rst = 1'b0;
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 1'b1, 5'd5);
`ifdef WB_HILO_EN
    hwe = 1'b1; lwe = 1'b1; hwd = 32'h11; lwd = 32'h22;
`endif

    // Reset held with a pending write to r5
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("rst_hold_p1", d1, '0);
      chk("rst_hold_p2", d2, '0);
      tick();
    end
`ifdef WB_HILO_EN
    hwe = 1'b0; lwe = 1'b0;
`endif
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b1, 5'd5, 1'b1, 5'd5);
    #1;
    chk("post_rst_r5_p1", d1, '0);
    chk("post_rst_r5_p2", d2, '0);
`ifdef WB_HILO_EN
    chk("post_rst_hi", hrd, '0);
    chk("post_rst_lo", lrd, '0);
`endif
    tick();

    tbl[0]  = '{1'b1, 5'd3,  32'h12345678, 1'b1, 5'd3,  1'b1, 5'd3,  32'h12345678, 32'h12345678};
    tbl[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  1'b0, 5'd3,  32'h12345678, 32'h0};
    tbl[2]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  1'b1, 5'd0,  32'h0,        32'h0};
    tbl[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b1, 5'd0,  32'h0,        32'h0};
    tbl[4]  = '{1'b1, 5'd7,  32'h00000001, 1'b1, 5'd1,  1'b1, 5'd7,  32'h0,        32'h00000001};
    tbl[5]  = '{1'b1, 5'd8,  32'hCAFE0008, 1'b1, 5'd7,  1'b1, 5'd7,  32'h00000001, 32'h00000001};
    tbl[6]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 1'b1, 5'd7,  1'b1, 5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5};
    tbl[7]  = '{1'b1, 5'd7,  32'h5A5A5A5A, 1'b1, 5'd7,  1'b1, 5'd8,  32'h5A5A5A5A, 32'hCAFE0008};
    tbl[8]  = '{1'b0, 5'd7,  32'h0,        1'b1, 5'd7,  1'b1, 5'd8,  32'h5A5A5A5A, 32'hCAFE0008};
    tbl[9]  = '{1'b1, 5'd31, 32'hFFFF0000, 1'b0, 5'd31, 1'b1, 5'd31, 32'h0,        32'hFFFF0000};
    tbl[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 1'b1, 5'd3,  32'hFFFF0000, 32'h12345678};

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].e1, tbl[i].a1, tbl[i].e2, tbl[i].a2);
      #1;
      chk($sformatf("vec%0d_p1", i), d1, tbl[i].x1);
      chk($sformatf("vec%0d_p2", i), d2, tbl[i].x2);
      tick();
    end

    // Fill r1..r31 with their own index, then read every one back
    for (int i = 1; i < NR; i++) begin
      drive(1'b1, AW'(i), DW'(i), 1'b0, '0, 1'b0, '0);
      tick();
    end
    for (int i = 0; i < NR; i++) begin
      drive(1'b0, '0, '0, 1'b1, AW'(i), 1'b1, AW'(NR - 1 - i));
      #1;
      chk($sformatf("fill_p1_r%0d", i), d1, DW'(i));
      chk($sformatf("fill_p2_r%0d", NR - 1 - i), d2, DW'(NR - 1 - i));
    end

    // Half-cycle reset pulse between edges with a write strobe present
    drive(1'b1, 5'd5, 32'h0BADF00D, 1'b1, 5'd5, 1'b1, 5'd9);
    rst = 1'b0;
    #1;
    chk("pulse_low_p1", d1, '0);
    chk("pulse_low_p2", d2, '0);
    drive(1'b0, '0, '0, 1'b1, 5'd5, 1'b1, 5'd9);
    #3;
    rst = 1'b1;
    #0.5;
    chk("pulse_rel_p1", d1, '0);
    chk("pulse_rel_p2", d2, '0);
    for (int i = 0; i < NR; i++) model[i] = '0;
    tick();
    for (int i = 0; i < NR; i++) begin
      drive(1'b0, '0, '0, 1'b1, AW'(i), 1'b1, AW'(i));
      #1;
      chk($sformatf("cleared_r%0d", i), d1 | d2, '0);
    end

`ifdef WB_HILO_EN
    hwe = 1'b1; lwe = 1'b1; hwd = 32'h1; lwd = 32'h2;
    #1;
    chk("hilo_byp_hi", hrd, 32'h1);
    chk("hilo_byp_lo", lrd, 32'h2);
    tick();
    hwe = 1'b0; lwe = 1'b1; hwd = 32'h9; lwd = 32'h3;
    #1;
    chk("hilo_lo_only_hi", hrd, 32'h1);
    chk("hilo_lo_only_lo", lrd, 32'h3);
    tick();
    hwe = 1'b0; lwe = 1'b0;
    #1;
    chk("hilo_hold_hi", hrd, 32'h1);
    chk("hilo_hold_lo", lrd, 32'h3);
`endif

    // Randomized traffic; addresses biased to a small range to exercise bypass
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] ra1, ra2, rwa;
      rwa = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      ra1 = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      ra2 = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      rst = ($urandom_range(0, 39) != 0);
      drive($urandom_range(0, 2) != 0, rwa, DW'($urandom),
            $urandom_range(0, 5) != 0, ra1, $urandom_range(0, 5) != 0, ra2);
      #1;
      chk("rand_p1", d1, ref_read(e1, a1));
      chk("rand_p2", d2, ref_read(e2, a2));
      if (!rst) for (int i = 0; i < NR; i++) model[i] = '0;
      tick();
      rst = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Architectural register file: the consumer end of the write-back stage.
- Sinks the registered write triple (data, address, enable) from the MEM/WB pipeline register.
- Serves two combinational read ports to the decode stage.
- Write-through bypass on both read ports, so a same-cycle write is visible without an extra forwarding path.
- Optional HI/LO pair for multiply/divide results, also written from write-back.

Parameters:
- DATA_W, 32, register data width (matches REG_DATA_BUS).
- ADDR_W, 5, register address width (matches REG_ADDR_BUS).
- NUM_REGS, 32, number of architectural registers; must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- wb_reg_write_en  in  1  write strobe from write-back.
- wb_reg_write_addr  in  ADDR_W  destination register.
- wb_reg_write_data  in  DATA_W  write data.
- reg1_read_en  in  1  read port 1 enable.
- reg1_read_addr  in  ADDR_W  read port 1 address.
- reg1_read_data  out  DATA_W  read port 1 data.
- reg2_read_en  in  1  read port 2 enable.
- reg2_read_addr  in  ADDR_W  read port 2 address.
- reg2_read_data  out  DATA_W  read port 2 data.
- wb_hi_write_en, wb_lo_write_en  in  1 each  HI/LO write strobes (WB_HILO_EN only).
- wb_hi_write_data, wb_lo_write_data  in  DATA_W each  HI/LO write data (WB_HILO_EN only).
- hi_read_data, lo_read_data  out  DATA_W each  HI/LO current value (WB_HILO_EN only).

Behaviour:
- Reset: rst low asynchronously clears all NUM_REGS entries (and HI/LO) to 0. While rst is low, every read output is forced to 0.
- Write timing: on a rising clk edge with rst high, wb_reg_write_en=1 and wb_reg_write_addr!=0, regs[addr] <= data.
- Register 0: writes to address 0 are discarded. Register 0 always reads 0.
- Write/reset collision: a write strobe present in the cycle rst is asserted, or on the edge where rst is still low, is dropped. There is no deferred write.
- Read ports are combinational with zero latency. Priority per port, highest first:
  1. rst low -> 0.
  2. read_en=0 -> 0.
  3. read_addr=0 -> 0.
  4. wb_reg_write_en=1 and wb_reg_write_addr==read_addr -> wb_reg_write_data (bypass).
  5. Otherwise -> regs[read_addr].
- Both ports may read the same address. Both may hit the bypass simultaneously; both return the write data.
- Write is single-port, so there are no write/write collisions.
- No X propagation: every entry has a defined value after reset.
- Out-of-range addresses cannot occur because NUM_REGS = 2**ADDR_W; this is checked with an elaboration-time assertion.

Optional Feature:
- Macro: WB_HILO_EN.
- Defined:
  - Adds HI and LO registers, each DATA_W wide, with independent write enables, cleared by rst.
  - Written on the rising edge when the corresponding enable is 1.
  - hi_read_data/lo_read_data bypass same-cycle write data exactly like the GPR ports.
  - Both enables may be 1 in the same cycle (mult/div result); both update.
- Undefined: HI/LO ports and storage are absent entirely; the GPR behaviour is unchanged.

Decomposition:
- Shared package/header (extend the existing regfile defines):
  - REG_DATA_BUS, REG_ADDR_BUS, REG_NUM.
  - ZERO_REG_ADDR (5'd0) and ZERO_WORD constants.
- One natural sub-module: wb_regfile_read_port.
  - Purely combinational: rst/en/zero/bypass/array-select priority mux.
  - Instantiated twice, and reused for HI/LO with address compare tied true.
- Storage array and write logic stay in the top module.

Test Plan:
- Reset: hold rst low 3 cycles while driving writes to r5=32'hDEADBEEF -> all reads 0. After release, read r5 = 0 (write dropped).
- Write r3=32'h12345678 at edge N -> port 1 reads 32'h12345678 from cycle N+1. Port 1 with read_en=0 at r3 -> 0.
- Write r0=32'hFFFFFFFF, then read r0 on both ports -> 0 in the write cycle and after.
- Bypass: r7 holds 32'h1. In the same cycle, write r7=32'hA5A5A5A5 and read r7 on both ports -> both return 32'hA5A5A5A5 immediately; port 2 reading r8 returns the stored r8.
- Mid-operation reset: fill r1..r31 with their own index. Pulse rst low for half a cycle between edges -> all reads 0 immediately and after release.
- With WB_HILO_EN: set both enables, hi=32'h1, lo=32'h2 -> same-cycle reads return 1 and 2. Next cycle, write only lo=32'h3 -> hi_read_data=1, lo_read_data=3.
